// File: rtl/hazard_unit_p.sv
// Pipeline hazard unit: operand forwarding select, load-use and memory/fetch stalls,
// redirect flushes and saturating stall/flush performance counters.
module hazard_unit_p #(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_BITS-1:0]           id_rs1,
  input  logic [REG_BITS-1:0]           id_rs2,
  input  logic                          id_rs1_use,
  input  logic                          id_rs2_use,
  input  logic [FWD_DEPTH-1:0]          p_wb,
  input  logic [FWD_DEPTH*REG_BITS-1:0] p_rd,
  input  logic [FWD_DEPTH-1:0]          p_rdy,
  input  logic                          redirect,
  input  logic                          i_resp,
  input  logic                          d_req,
  input  logic                          d_resp,
  input  logic                          clr_cnt,
  output logic [SEL_W-1:0]              fwd1_sel,
  output logic [SEL_W-1:0]              fwd2_sel,
  output logic                          stall_id,
  output logic                          stall_all,
  output logic                          bubble_ex,
  output logic                          flush_if_id,
  output logic                          flush_id_ex,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  logic d_done, i_done, redir_pend;
  logic mem_busy, fetch_busy, flush;
  logic stall1, stall2, data_stall;

  // Returns {stall, sel}; scanning from the far stage inward lets the nearest match win.
  function automatic logic [SEL_W:0] resolve(
    input logic [REG_BITS-1:0]           rs,
    input logic                          src_used,
    input logic [FWD_DEPTH-1:0]          wb,
    input logic [FWD_DEPTH*REG_BITS-1:0] rd,
    input logic [FWD_DEPTH-1:0]          rdy
  );
    logic             hit;
    logic             hit_rdy;
    logic [SEL_W-1:0] hit_sel;
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_sel = '0;
    for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
      if (src_used && (rs != '0) && wb[k] && (rd[k*REG_BITS +: REG_BITS] == rs)) begin
        hit     = 1'b1;
        hit_rdy = rdy[k];
        hit_sel = SEL_W'(k + 1);
      end
    end
    return {hit & ~hit_rdy, (hit & hit_rdy) ? hit_sel : SEL_W'(0)};
  endfunction

  always_comb begin
    {stall1, fwd1_sel} = resolve(id_rs1, id_rs1_use, p_wb, p_rd, p_rdy);
    {stall2, fwd2_sel} = resolve(id_rs2, id_rs2_use, p_wb, p_rd, p_rdy);
    data_stall = stall1 | stall2;
  end

  // A response that arrives while everything is frozen is remembered until the freeze ends.
  always_comb begin
    mem_busy    = d_req & ~d_resp & ~d_done;
    fetch_busy  = ~i_resp & ~i_done;
    stall_all   = mem_busy | fetch_busy;
    flush       = (redirect | redir_pend) & ~stall_all;
    flush_if_id = flush;
    flush_id_ex = flush;
    if (flush) begin
      stall_id  = stall_all;
      bubble_ex = 1'b0;
    end else begin
      stall_id  = stall_all | data_stall;
      bubble_ex = data_stall & ~stall_all;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_done     <= 1'b0;
      i_done     <= 1'b0;
      redir_pend <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      d_done     <= stall_all & (d_done | d_resp);
      i_done     <= stall_all & (i_done | i_resp);
      redir_pend <= ~flush & (redir_pend | (redirect & stall_all));
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Scoreboard bench for hazard_unit_p: directed scenarios then random traffic against a
// cycle-level reference model; expectations are queued and checked by a separate monitor.
module tb_hazard_unit_p;

  localparam int unsigned FD = 3;
  localparam int unsigned RB = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 2;
  localparam int CMAX = 15;

  typedef struct {
    logic          rst, clr;
    logic [RB-1:0] rs1, rs2;
    logic          u1, u2;
    logic [FD-1:0] wb, rdy;
    logic [RB-1:0] rd [FD];
    logic          redirect, i_resp, d_req, d_resp;
  } stim_t;

  typedef struct {
    int fwd1, fwd2, stall_id, stall_all, bubble, flush, scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RB-1:0] id_rs1 = '0, id_rs2 = '0;
  logic id_rs1_use = 1'b0, id_rs2_use = 1'b0;
  logic [FD-1:0] p_wb = '0, p_rdy = '0;
  logic [FD*RB-1:0] p_rd = '0;
  logic redirect = 1'b0, i_resp = 1'b1, d_req = 1'b0, d_resp = 1'b0, clr_cnt = 1'b0;
  logic [SW-1:0] fwd1_sel, fwd2_sel;
  logic stall_id, stall_all, bubble_ex, flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_unit_p #(.FWD_DEPTH(FD), .REG_BITS(RB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .p_wb(p_wb), .p_rd(p_rd), .p_rdy(p_rdy),
    .redirect(redirect), .i_resp(i_resp), .d_req(d_req), .d_resp(d_resp),
    .clr_cnt(clr_cnt),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_id(stall_id), .stall_all(stall_all),
    .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t sb_q[$];

  // Reference model state: what the pipeline remembers across cycles.
  bit m_dgot, m_igot, m_redir;
  int m_scnt, m_fcnt;
  stim_t prev_s;
  exp_t  prev_e;
  bit    have_prev = 1'b0;

  function automatic void src_eval(input stim_t s, input logic [RB-1:0] rs, input logic u,
                                   output int sel, output bit stall);
    sel = 0;
    stall = 1'b0;
    if (u && rs != 0) begin
      for (int k = 0; k < int'(FD); k++) begin
        if (s.wb[k] && s.rd[k] == rs) begin
          if (s.rdy[k]) sel = k + 1;
          else stall = 1'b1;
          break;
        end
      end
    end
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit st1, st2, waiting_mem, waiting_fetch, frozen, fl;
    src_eval(s, s.rs1, s.u1, e.fwd1, st1);
    src_eval(s, s.rs2, s.u2, e.fwd2, st2);
    waiting_mem   = s.d_req && !s.d_resp && !m_dgot;
    waiting_fetch = !s.i_resp && !m_igot;
    frozen = waiting_mem || waiting_fetch;
    fl = (s.redirect || m_redir) && !frozen;
    e.stall_all = int'(frozen);
    e.flush     = int'(fl);
    e.stall_id  = int'(frozen || (!fl && (st1 || st2)));
    e.bubble    = int'(!fl && !frozen && (st1 || st2));
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    return e;
  endfunction

  task automatic model_edge(input stim_t s, input exp_t e);
    if (s.rst) begin
      m_dgot = 0; m_igot = 0; m_redir = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      m_dgot  = (e.stall_all != 0) && (m_dgot || s.d_resp);
      m_igot  = (e.stall_all != 0) && (m_igot || s.i_resp);
      m_redir = (e.flush == 0) && (m_redir || (s.redirect && e.stall_all != 0));
      if (s.clr) begin
        m_scnt = 0; m_fcnt = 0;
      end else begin
        m_scnt = (m_scnt + e.stall_id > CMAX) ? CMAX : m_scnt + e.stall_id;
        m_fcnt = (m_fcnt + e.flush > CMAX) ? CMAX : m_fcnt + e.flush;
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (have_prev) model_edge(prev_s, prev_e);
    #1;
    rst = s.rst; clr_cnt = s.clr;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rs1_use = s.u1; id_rs2_use = s.u2;
    p_wb = s.wb; p_rdy = s.rdy;
    for (int k = 0; k < int'(FD); k++) p_rd[k*RB +: RB] = s.rd[k];
    redirect = s.redirect; i_resp = s.i_resp; d_req = s.d_req; d_resp = s.d_resp;
    e = model_out(s);
    sb_q.push_back(e);
    prev_s = s; prev_e = e; have_prev = 1'b1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.clr = 0; s.rs1 = 0; s.rs2 = 0; s.u1 = 0; s.u2 = 0;
    s.wb = '0; s.rdy = '0;
    for (int k = 0; k < int'(FD); k++) s.rd[k] = '0;
    s.redirect = 0; s.i_resp = 1; s.d_req = 0; s.d_resp = 0;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle presents a result; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("fwd1_sel", int'(fwd1_sel), e.fwd1);
        chk("fwd2_sel", int'(fwd2_sel), e.fwd2);
        chk("stall_id", int'(stall_id), e.stall_id);
        chk("stall_all", int'(stall_all), e.stall_all);
        chk("bubble_ex", int'(bubble_ex), e.bubble);
        chk("flush_if_id", int'(flush_if_id), e.flush);
        chk("flush_id_ex", int'(flush_id_ex), e.flush);
        chk("stall_cnt", int'(stall_cnt), e.scnt);
        chk("flush_cnt", int'(flush_cnt), e.fcnt);
      end
    end
  end

  initial begin
    stim_t s;
    m_dgot = 0; m_igot = 0; m_redir = 0; m_scnt = 0; m_fcnt = 0;
    repeat (2) @(posedge clk);

    // Reset held with noisy inputs.
    s = idle(); s.rst = 1; s.i_resp = 0; s.d_req = 1; s.redirect = 1;
    step(s); step(s);

    // Nearest producer wins when two stages match.
    s = idle(); s.rs1 = 5; s.u1 = 1; s.wb = 3'b011; s.rd[0] = 5; s.rd[1] = 5; s.rdy = 3'b011;
    step(s);
    // Load-use on rs2 with fetch and memory idle: bubble and count.
    s = idle(); s.rs2 = 7; s.u2 = 1; s.wb = 3'b001; s.rd[0] = 7; s.rdy = 3'b000;
    step(s); step(s);
    // Register zero never forwards or stalls.
    s = idle(); s.rs1 = 0; s.u1 = 1; s.wb = 3'b001; s.rd[0] = 0; s.rdy = 3'b000;
    step(s);

    // Data response during a fetch miss is held until the fetch returns.
    s = idle(); s.d_req = 1; s.i_resp = 0;
    step(s); step(s);
    s.d_resp = 1; step(s);
    s.d_resp = 0; step(s); step(s);
    s.i_resp = 1; step(s);
    step(idle());

    // Redirect during a freeze becomes a single flush once released.
    s = idle(); s.i_resp = 0; s.redirect = 1; step(s);
    s.redirect = 0; step(s); step(s);
    s.i_resp = 1; step(s); step(s);

    // Saturating stall counter, then clear alongside a stall.
    s = idle(); s.rs1 = 3; s.u1 = 1; s.wb = 3'b100; s.rd[2] = 3; s.rdy = 3'b000;
    repeat (18) step(s);
    s.clr = 1; step(s);
    s.clr = 0; step(s);

    // Reset in the middle of a freeze with a pending redirect and held response.
    s = idle(); s.i_resp = 0; s.d_req = 1; s.d_resp = 1; s.redirect = 1; step(s);
    s.d_resp = 0; s.redirect = 0; s.rst = 1; step(s);
    s.rst = 0; s.d_req = 0; s.i_resp = 1; step(s); step(s);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 199) == 0);
      s.clr = ($urandom_range(0, 99) == 0);
      s.rs1 = RB'($urandom_range(0, 3));
      s.rs2 = RB'($urandom_range(0, 3));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom);
      s.wb = FD'($urandom); s.rdy = FD'($urandom);
      for (int k = 0; k < int'(FD); k++) s.rd[k] = RB'($urandom_range(0, 3));
      s.redirect = ($urandom_range(0, 7) == 0);
      s.i_resp = ($urandom_range(0, 3) != 0);
      s.d_req = ($urandom_range(0, 2) == 0);
      s.d_resp = ($urandom_range(0, 2) == 0);
      step(s);
    end

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
